// File: rtl/pll_lock_monitor_pkg.sv
// Shared widths, FSM state type and the popcount-distance helper for the PLL lock monitor.
package pll_lock_pkg;

  localparam int TRIM_W = 26;
  localparam int DIV_W  = 5;
  localparam int POP_W  = 5;
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACQUIRE,
    ST_LOCKED,
    ST_TIMEOUT
  } lock_state_t;

  // Magnitude of a - b, computed as a signed 6-bit difference so it never wraps.
  function automatic logic [POP_W:0] pop_distance(input logic [POP_W-1:0] a,
                                                  input logic [POP_W-1:0] b);
    logic signed [POP_W:0] diff;
    diff = signed'({1'b0, a}) - signed'({1'b0, b});
    return (diff < 0) ? $unsigned(-diff) : $unsigned(diff);
  endfunction

endpackage

// File: rtl/pll_lock_monitor_if.sv
// Bundle of PLL-side controls and monitor results; the monitor is the slave side.
interface pll_lock_monitor_if
  import pll_lock_pkg::*;
  ;

  logic              enable;
  logic [DIV_W-1:0]  div;
  logic [TRIM_W-1:0] trim;
  logic              locked;
  logic              timeout;
  logic [CNT_W-1:0]  lock_cycles;
  logic [POP_W-1:0]  lock_ref;
  logic [7:0]        unlock_count;

  modport master (
    output enable, div, trim,
    input  locked, timeout, lock_cycles, lock_ref, unlock_count
  );

  modport slave (
    input  enable, div, trim,
    output locked, timeout, lock_cycles, lock_ref, unlock_count
  );

endinterface

// File: rtl/trim_popcount.sv
// Combinational count of set bits in the DCO trim word.
module trim_popcount
  import pll_lock_pkg::*;
(
  input  logic [TRIM_W-1:0] trim,
  output logic [POP_W-1:0]  count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < TRIM_W; i++) begin
      count = count + POP_W'(trim[i]);
    end
  end

endmodule

// File: rtl/pll_lock_monitor.sv
// Watches the trim popcount for stability to declare lock, flags slow acquisition
// and counts loss-of-lock events.
module pll_lock_monitor
  import pll_lock_pkg::*;
#(
  parameter int STABLE_CYCLES = 5,
  parameter int MAX_WAIT      = 50,
  parameter int UNLOCK_TOL    = 1
) (
  input  logic             osc,
  input  logic             resetb,
  pll_lock_monitor_if.slave mon
);

  localparam int STB_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [POP_W:0] TOL = (POP_W + 1)'(UNLOCK_TOL);

  logic [POP_W-1:0] p;

  lock_state_t      state_reg, state_next;
  logic [POP_W-1:0] p_prev_reg, p_prev_next;
  logic [DIV_W-1:0] div_q_reg, div_q_next;
  logic [STB_W-1:0] stable_cnt_reg, stable_cnt_next;
  logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic             locked_reg, locked_next;
  logic             timeout_reg, timeout_next;
  logic [CNT_W-1:0] lock_cycles_reg, lock_cycles_next;
  logic [POP_W-1:0] lock_ref_reg, lock_ref_next;
  logic [7:0]       unlock_count_reg, unlock_count_next;

  logic [CNT_W-1:0] wait_inc;
  logic [STB_W-1:0] stable_upd;
  logic             div_changed;
  logic             out_of_tol;
  logic             restart;

  trim_popcount u_popcount (
    .trim  (mon.trim),
    .count (p)
  );

  assign wait_inc    = wait_cnt_reg + CNT_W'(1);
  assign stable_upd  = (p == p_prev_reg) ? stable_cnt_reg + STB_W'(1) : '0;
  assign div_changed = (mon.div != div_q_reg);
  assign out_of_tol  = (pop_distance(p, lock_ref_reg) > TOL);

  always_comb begin
    state_next        = state_reg;
    p_prev_next       = p_prev_reg;
    div_q_next        = div_q_reg;
    stable_cnt_next   = stable_cnt_reg;
    wait_cnt_next     = wait_cnt_reg;
    locked_next       = locked_reg;
    timeout_next      = timeout_reg;
    lock_cycles_next  = lock_cycles_reg;
    lock_ref_next     = lock_ref_reg;
    unlock_count_next = unlock_count_reg;
    restart           = 1'b0;

    if (!mon.enable) begin
      state_next   = ST_IDLE;
      locked_next  = 1'b0;
      timeout_next = 1'b0;
    end else if (state_reg == ST_IDLE) begin
      restart = 1'b1;
    end else if (div_changed) begin
      restart      = 1'b1;
      locked_next  = 1'b0;
      timeout_next = 1'b0;
    end else begin
      case (state_reg)
        ST_ACQUIRE: begin
          wait_cnt_next   = wait_inc;
          stable_cnt_next = stable_upd;
          p_prev_next     = p;
          if (stable_upd == STB_W'(STABLE_CYCLES)) begin
            state_next       = ST_LOCKED;
            locked_next      = 1'b1;
            lock_ref_next    = p;
            lock_cycles_next = wait_inc;
          end else if (wait_inc == CNT_W'(MAX_WAIT)) begin
            state_next   = ST_TIMEOUT;
            timeout_next = 1'b1;
          end
        end
        ST_LOCKED: begin
          if (out_of_tol) begin
            restart     = 1'b1;
            locked_next = 1'b0;
            if (unlock_count_reg != 8'hFF) begin
              unlock_count_next = unlock_count_reg + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end

    // Every path into acquisition starts from the current popcount and divider.
    if (restart) begin
      state_next      = ST_ACQUIRE;
      p_prev_next     = p;
      div_q_next      = mon.div;
      stable_cnt_next = '0;
      wait_cnt_next   = '0;
    end
  end

  always_ff @(posedge osc) begin
    if (!resetb) begin
      state_reg        <= ST_IDLE;
      p_prev_reg       <= '0;
      div_q_reg        <= '0;
      stable_cnt_reg   <= '0;
      wait_cnt_reg     <= '0;
      locked_reg       <= 1'b0;
      timeout_reg      <= 1'b0;
      lock_cycles_reg  <= '0;
      lock_ref_reg     <= '0;
      unlock_count_reg <= '0;
    end else begin
      state_reg        <= state_next;
      p_prev_reg       <= p_prev_next;
      div_q_reg        <= div_q_next;
      stable_cnt_reg   <= stable_cnt_next;
      wait_cnt_reg     <= wait_cnt_next;
      locked_reg       <= locked_next;
      timeout_reg      <= timeout_next;
      lock_cycles_reg  <= lock_cycles_next;
      lock_ref_reg     <= lock_ref_next;
      unlock_count_reg <= unlock_count_next;
    end
  end

  assign mon.locked       = locked_reg;
  assign mon.timeout      = timeout_reg;
  assign mon.lock_cycles  = lock_cycles_reg;
  assign mon.lock_ref     = lock_ref_reg;
  assign mon.unlock_count = unlock_count_reg;

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Directed scenarios plus randomized traffic checked against a history-based model.
module tb_pll_lock_monitor;
  import pll_lock_pkg::*;

  localparam int SC  = 5;
  localparam int MW  = 50;
  localparam int TOL = 1;

  logic osc = 1'b0;
  logic resetb = 1'b0;
  pll_lock_monitor_if bus ();

  pll_lock_monitor #(
    .STABLE_CYCLES (SC),
    .MAX_WAIT      (MW),
    .UNLOCK_TOL    (TOL)
  ) dut (
    .osc    (osc),
    .resetb (resetb),
    .mon    (bus)
  );

  always #5 osc = ~osc;

  int total = 0;
  int bad   = 0;

  // Model: acquisition is a list of popcounts seen since acquisition began.
  int m_active;   // 0 off, 1 acquiring, 2 locked, 3 timed out
  int hist[$];
  int m_div;
  int m_locked, m_timeout, m_lock_cycles, m_lock_ref, m_unlocks;
  int cur_k;

  task automatic check_eq(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [TRIM_W-1:0] mk_trim(input int k);
    logic [TRIM_W-1:0] t;
    t = '0;
    while ($countones(t) < k) t[$urandom_range(TRIM_W-1, 0)] = 1'b1;
    return t;
  endfunction

  function automatic int trailing_run();
    int n = 1;
    for (int i = hist.size() - 1; i > 0; i--) begin
      if (hist[i] == hist[i-1]) n++;
      else break;
    end
    return n;
  endfunction

  task automatic begin_acq(input int p, input int dv);
    hist.delete();
    hist.push_back(p);
    m_div    = dv;
    m_active = 1;
  endtask

  task automatic model_edge(input bit rb, input bit en, input int dv, input int p);
    int d;
    if (!rb) begin
      m_active = 0; hist.delete(); m_div = 0;
      m_locked = 0; m_timeout = 0; m_lock_cycles = 0; m_lock_ref = 0; m_unlocks = 0;
    end else if (!en) begin
      m_active = 0; m_locked = 0; m_timeout = 0;
    end else if (m_active == 0) begin
      begin_acq(p, dv);
    end else if (dv != m_div) begin
      begin_acq(p, dv);
      m_locked = 0; m_timeout = 0;
    end else if (m_active == 1) begin
      hist.push_back(p);
      if (trailing_run() == SC + 1) begin
        m_active = 2; m_locked = 1; m_lock_ref = p; m_lock_cycles = hist.size() - 1;
      end else if (hist.size() - 1 == MW) begin
        m_active = 3; m_timeout = 1;
      end
    end else if (m_active == 2) begin
      d = p - m_lock_ref;
      if (d < 0) d = -d;
      if (d > TOL) begin
        if (m_unlocks < 255) m_unlocks++;
        begin_acq(p, dv);
        m_locked = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge osc);
    model_edge(resetb, bus.enable, int'(bus.div), $countones(bus.trim));
    #1;
    check_eq("locked", int'(bus.locked), m_locked);
    check_eq("timeout", int'(bus.timeout), m_timeout);
    check_eq("lock_cycles", int'(bus.lock_cycles), m_lock_cycles);
    check_eq("lock_ref", int'(bus.lock_ref), m_lock_ref);
    check_eq("unlock_count", int'(bus.unlock_count), m_unlocks);
  endtask

  task automatic set_pop(input int k);
    cur_k    = k;
    bus.trim = mk_trim(k);
  endtask

  task automatic do_reset();
    resetb = 1'b0;
    tick();
    resetb = 1'b1;
  endtask

  initial begin
    bus.enable = 1'b0;
    bus.div    = 5'd17;
    bus.trim   = '0;
    cur_k      = 0;
    resetb     = 1'b0;
    model_edge(1'b0, 1'b0, 0, 0);
    tick();
    tick();
    check_eq("rst_locked", int'(bus.locked), 0);
    check_eq("rst_unlocks", int'(bus.unlock_count), 0);
    resetb = 1'b1;

    // Constant trim: lock on the 5th acquisition edge.
    bus.enable = 1'b1;
    bus.div    = 5'd17;
    bus.trim   = 26'h0003FFF;
    cur_k      = 14;
    tick();
    for (int i = 1; i <= 4; i++) tick();
    check_eq("lock_early", int'(bus.locked), 0);
    tick();
    check_eq("lock_set", int'(bus.locked), 1);
    check_eq("lock_cycles5", int'(bus.lock_cycles), 5);
    check_eq("lock_ref14", int'(bus.lock_ref), 14);
    $display("txn lock: locked=%0d lock_cycles=%0d lock_ref=%0d", bus.locked, bus.lock_cycles, bus.lock_ref);

    // Within tolerance at p=15, out of tolerance at p=16.
    for (int i = 0; i < 3; i++) begin
      set_pop(15);
      tick();
      check_eq("tol_hold", int'(bus.locked), 1);
    end
    set_pop(16);
    tick();
    check_eq("unlock_cnt1", int'(bus.unlock_count), 1);
    check_eq("unlock_drop", int'(bus.locked), 0);
    for (int i = 0; i < 5; i++) tick();
    check_eq("relock16", int'(bus.locked), 1);
    $display("txn unlock: unlock_count=%0d lock_ref=%0d", bus.unlock_count, bus.lock_ref);

    // Divider change outranks unlock on the same edge.
    bus.div = 5'd18;
    set_pop(20);
    tick();
    check_eq("div_drop", int'(bus.locked), 0);
    check_eq("div_no_unlock", int'(bus.unlock_count), 1);
    for (int i = 1; i <= 4; i++) tick();
    check_eq("div_relock_early", int'(bus.locked), 0);
    tick();
    check_eq("div_relock", int'(bus.locked), 1);
    check_eq("div_ref20", int'(bus.lock_ref), 20);
    $display("txn divchg: locked=%0d unlock_count=%0d", bus.locked, bus.unlock_count);

    // Enable drop mid-acquisition, then reset mid-acquisition.
    set_pop(10);
    tick();
    tick();
    tick();
    bus.enable = 1'b0;
    tick();
    check_eq("en_hold_cycles", int'(bus.lock_cycles), 5);
    bus.enable = 1'b1;
    tick();
    tick();
    resetb = 1'b0;
    tick();
    check_eq("rst_cycles", int'(bus.lock_cycles), 0);
    check_eq("rst_ref", int'(bus.lock_ref), 0);
    check_eq("rst_unl", int'(bus.unlock_count), 0);
    resetb = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("post_rst_nolock", int'(bus.locked), 0);
    end
    tick();
    check_eq("post_rst_lock", int'(bus.locked), 1);
    $display("txn enable/reset: lock_cycles=%0d locked=%0d", bus.lock_cycles, bus.locked);

    // Toggling popcount never settles: timeout on the 50th edge and it sticks.
    do_reset();
    bus.div = 5'd17;
    set_pop(13);
    tick();
    for (int i = 1; i <= MW + 10; i++) begin
      set_pop((i % 2) ? 14 : 13);
      tick();
      if (i == MW - 1) check_eq("timeout_early", int'(bus.timeout), 0);
      if (i >= MW) check_eq("timeout_hold", int'(bus.timeout), 1);
    end
    check_eq("timeout_nolock", int'(bus.locked), 0);
    $display("txn timeout: timeout=%0d locked=%0d", bus.timeout, bus.locked);

    // 256 unlock events saturate the counter.
    do_reset();
    set_pop(14);
    for (int i = 0; i < 6; i++) tick();
    for (int n = 0; n < 256; n++) begin
      set_pop((cur_k == 14) ? 20 : 14);
      for (int i = 0; i < 6; i++) tick();
    end
    check_eq("sat255", int'(bus.unlock_count), 255);
    $display("txn saturate: unlock_count=%0d", bus.unlock_count);

    // Randomized traffic; trim bit positions reshuffle every edge.
    for (int c = 0; c < 3000; c++) begin
      resetb     = ($urandom_range(299, 0) != 0);
      bus.enable = ($urandom_range(59, 0) != 0);
      if ($urandom_range(79, 0) == 0) bus.div = 5'($urandom_range(31, 0));
      case ($urandom_range(9, 0))
        0:       cur_k = $urandom_range(TRIM_W, 0);
        1:       cur_k = (cur_k < TRIM_W) ? cur_k + 1 : cur_k;
        2:       cur_k = (cur_k > 0) ? cur_k - 1 : cur_k;
        default: ;
      endcase
      set_pop(cur_k);
      tick();
    end
    $display("txn random: unlock_count=%0d locked=%0d timeout=%0d", bus.unlock_count, bus.locked, bus.timeout);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pll_lock_monitor.md
PLL_LOCK_MONITOR -- requirements
Module: pll_lock_monitor

Interface
REQ-001 Parameter STABLE_CYCLES, default 5: consecutive equal-trim comparisons needed to declare lock.
REQ-002 Parameter MAX_WAIT, default 50: osc cycles allowed in acquisition before timeout; range 1..65535.
REQ-003 Parameter UNLOCK_TOL, default 1: maximum allowed |trim popcount − lock_ref| while locked.
REQ-004 osc  in  1  reference clock; single clock domain; all state changes on posedge osc.
REQ-005 resetb  in  1  synchronous, active-low reset, sampled on posedge osc.
REQ-006 enable  in  1  monitor enable; mirrors the PLL enable.
REQ-007 div  in  5  PLL feedback divider setting.
REQ-008 trim  in  26  DCO trim word from the PLL controller.
REQ-009 locked  out  1  registered lock indication.
REQ-010 timeout  out  1  registered flag: acquisition exceeded MAX_WAIT.
REQ-011 lock_cycles  out  16  osc cycles from acquisition start to lock; holds until the next lock.
REQ-012 lock_ref  out  5  trim popcount captured at lock.
REQ-013 unlock_count  out  8  number of loss-of-lock events, saturating.

Function
REQ-014 p = popcount(trim), 0..26, 5 bits, combinational; all comparisons use p, never raw trim.
REQ-015 FSM states: IDLE, ACQUIRE, LOCKED, TIMEOUT.
REQ-016 Priority each edge: enable low > div change > lock > timeout > unlock.
REQ-017 Any state, enable low: next state IDLE; locked and timeout clear; lock_cycles, lock_ref and unlock_count hold.
REQ-018 IDLE with enable high: next state ACQUIRE; load p_prev<=p and div_q<=div; clear stable_cnt and wait_cnt.
REQ-019 Div change: in ACQUIRE, LOCKED or TIMEOUT, div != div_q re-enters ACQUIRE with the REQ-018 loads. It clears locked and timeout and does not increment unlock_count.
REQ-020 ACQUIRE, each edge: wait_cnt<=wait_cnt+1; stable_cnt<=(p==p_prev)?stable_cnt+1:0; p_prev<=p.
REQ-021 Lock: in ACQUIRE, when the updated stable_cnt equals STABLE_CYCLES, then on that edge state<=LOCKED, locked<=1, lock_ref<=p, lock_cycles<=wait_cnt+1.
REQ-022 Timeout: in ACQUIRE, when wait_cnt+1 == MAX_WAIT and REQ-021 does not fire, then state<=TIMEOUT and timeout<=1.
REQ-023 TIMEOUT is held until a div change or enable low; trim is ignored.
REQ-024 Unlock: in LOCKED, when |p − lock_ref| > UNLOCK_TOL, then on that edge state<=ACQUIRE, locked<=0, and unlock_count increments, saturating at 255; the REQ-018 loads apply.
REQ-025 Counter widths: wait_cnt is 16 bits, stable_cnt is at least $clog2(STABLE_CYCLES+1) bits, and the difference is computed signed 6-bit with no wrap.
REQ-026 With constant trim, locked asserts on the STABLE_CYCLES-th edge after ACQUIRE entry, and lock_cycles equals STABLE_CYCLES.

Reset
REQ-027 When resetb is low at a posedge, state<=IDLE and all outputs and internal counters clear to 0; reset overrides every other event.
REQ-028 A reset in the middle of acquisition discards progress; after reset releases, re-acquisition starts from REQ-018.

Structure
REQ-029 Package pll_lock_pkg holds the FSM state enum, TRIM_W=26, DIV_W=5, POP_W=5 and CNT_W=16.
REQ-030 One sub-module, trim_popcount (26-bit in, 5-bit out, combinational), is instantiated once.

Verification
REQ-031 Lock: reset, then enable=1, div=17, trim held at 26'h0003FFF (p=14) → locked=1 after the 5th edge in ACQUIRE, lock_cycles=5, lock_ref=14.
REQ-032 Timeout: enable=1 with trim toggling every edge between p=13 and p=14 → timeout=1 at wait_cnt=50; locked stays 0 and the flag holds while toggling continues.
REQ-033 Unlock: while locked with lock_ref=14, drive p=15 for 3 edges and then p=16 → stays locked at p=15; at p=16, unlock_count=1, locked=0 and re-acquisition starts.
REQ-034 Div change: while locked, change div 17→18 in the same edge that p jumps to 20 → state ACQUIRE, unlock_count unchanged, and re-lock 5 edges after trim settles.
REQ-035 Enable and reset: drop enable while in ACQUIRE → IDLE with lock_cycles held; assert resetb=0 mid-ACQUIRE → all outputs 0 on the next edge, and no lock for at least 5 edges after release.
REQ-036 Saturation: force 256 unlock events → unlock_count stays at 255.
